// File: rtl/seq_multiplier.sv
// 4x4 unsigned shift-and-add multiplier: one partial product per clock,
// 8-bit registered product, IDLE/CALC/DONE handshake on go.
module seq_multiplier (
    input  logic       CLK,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] product,
    output logic       Done,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  a;
    logic [3:0]  b;
    logic [2:0]  cnt;
    logic        operand_zero;

    assign operand_zero = (x == '0) || (y == '0);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = operand_zero ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: state_nxt = (cnt == 3'd1) ? DONE : CALC;
            // Stay in DONE until go drops, so a held go never restarts.
            DONE: state_nxt = go ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            product <= '0;
            a       <= '0;
            b       <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        product <= '0;
                        if (!operand_zero) begin
                            a   <= {4'b0000, x};
                            b   <= y;
                            cnt <= 3'd4;
                        end
                    end
                end
                CALC: begin
                    if (b[0]) begin
                        product <= product + a;
                    end
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt - 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Done = (state == DONE);
    assign Busy = (state == CALC);

endmodule
